// File: rtl/trip_filter_pkg.sv
// ============================================================================
// Module      : trip_filter_pkg
// Description : Shared types and constants for the trip_filter block:
//               FSM state encoding, event counter width and parameter
//               defaults, plus a saturating counter increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trip_filter_pkg;

    // Event counter width and its saturation ceiling
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Parameter defaults shared by the top and its integrators
    localparam int TRIP_CNT_DEF  = 4;
    localparam int CLEAR_CNT_DEF = 8;
    localparam int TIMEOUT_DEF   = 1000;

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        PEND_TRIP  = 2'd1,
        TRIPPED    = 2'd2,
        PEND_CLEAR = 2'd3
    } tf_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping to zero
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trip_filter_range_cmp.sv
// ============================================================================
// Module      : range_cmp
// Description : Combinational window comparator. A sample is in range when
//               thr_lo <= sample <= thr_hi (unsigned, both ends inclusive).
//               An inverted window (thr_lo > thr_hi) is a configuration
//               error and rejects every sample.
// Ports       : sample, thr_lo, thr_hi  - unsigned DATA_W inputs
//               in_range                - sample lies inside the window
//               cfg_err_next            - window is inverted (unregistered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_cmp
    import trip_filter_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic [DATA_W-1:0] thr_hi,
    output logic              in_range,
    output logic              cfg_err_next
);

    assign cfg_err_next = (thr_lo > thr_hi);
    assign in_range     = !cfg_err_next && (sample >= thr_lo) && (sample <= thr_hi);

endmodule

`default_nettype wire

// File: rtl/trip_filter.sv
// ============================================================================
// Module      : trip_filter
// Description : Debounced over/under-range trip detector. TRIP_CNT
//               consecutive out-of-range valid samples declare a fault
//               (ok=0); CLEAR_CNT consecutive in-range valid samples restore
//               health (ok=1). ok drives the active-low error input of the
//               downstream hold-error latch.
// Config      : `define TRIP_FILTER_TIMEOUT_EN adds a sample watchdog: after
//               TIMEOUT clk cycles without a valid sample the block raises
//               stale and forces TRIPPED. Without it stale is tied to 0.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               sample_valid      - sample qualifier
//               sample            - unsigned raw sensor value
//               thr_hi, thr_lo    - inclusive unsigned window limits
//               ok                - 1 healthy / 0 fault (registered)
//               pending           - trip or clear count in progress (reg.)
//               cfg_err           - thr_lo > thr_hi (registered)
//               stale             - sample watchdog expired (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trip_filter
    import trip_filter_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int TRIP_CNT  = TRIP_CNT_DEF,
    parameter int CLEAR_CNT = CLEAR_CNT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              ok,
    output logic              pending,
    output logic              cfg_err,
    output logic              stale
);

    // Reject illegal configurations at elaboration time
    generate
        if (TRIP_CNT < 1 || TRIP_CNT > 255 || CLEAR_CNT < 1 || CLEAR_CNT > 255
            || TIMEOUT < 1) begin : g_bad_param
            $error("trip_filter: TRIP_CNT/CLEAR_CNT must be 1..255, TIMEOUT >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TRIP_LIM  = CNT_W'(TRIP_CNT);
    localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(CLEAR_CNT);

    logic             in_range;
    logic             cfg_err_next;
    tf_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ok_q, pending_q, cfg_err_q;

    range_cmp #(.DATA_W(DATA_W)) u_range_cmp (
        .sample       (sample),
        .thr_lo       (thr_lo),
        .thr_hi       (thr_hi),
        .in_range     (in_range),
        .cfg_err_next (cfg_err_next)
    );

    assign cnt_inc = cnt_inc_sat(cnt_q);

`ifdef TRIP_FILTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_TOP  = TMR_W'(TIMEOUT);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             stale_q, stale_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_valid) begin
            case (state_q)
                NORMAL: begin
                    if (!in_range) begin
                        cnt_d   = 8'd1;
                        state_d = (TRIP_CNT == 1) ? TRIPPED : PEND_TRIP;
                    end
                end
                PEND_TRIP: begin
                    if (!in_range) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= TRIP_LIM) begin
                            state_d = TRIPPED;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Any good sample aborts the trip; no accumulation
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end
                end
                TRIPPED: begin
                    if (in_range) begin
                        cnt_d   = 8'd1;
                        state_d = (CLEAR_CNT == 1) ? NORMAL : PEND_CLEAR;
                    end
                end
                PEND_CLEAR: begin
                    if (in_range) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CLEAR_LIM) begin
                            state_d = NORMAL;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = TRIPPED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end

`ifdef TRIP_FILTER_TIMEOUT_EN
        // Watchdog: a valid sample always wins over expiry in the same cycle.
        // Once expired the timer parks at TIMEOUT and keeps TRIPPED forced.
        tmr_d   = tmr_q;
        stale_d = stale_q;
        if (sample_valid) begin
            tmr_d   = '0;
            stale_d = 1'b0;
        end else if (tmr_q >= TMR_LAST) begin
            tmr_d   = TMR_TOP;
            stale_d = 1'b1;
            state_d = TRIPPED;
            cnt_d   = '0;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
`endif
    end

    // Outputs are decoded from the next state so they settle with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= NORMAL;
            cnt_q     <= '0;
            ok_q      <= 1'b1;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef TRIP_FILTER_TIMEOUT_EN
            tmr_q     <= '0;
            stale_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ok_q      <= !((state_d == TRIPPED) || (state_d == PEND_CLEAR));
            pending_q <= (state_d == PEND_TRIP) || (state_d == PEND_CLEAR);
            cfg_err_q <= cfg_err_next;
`ifdef TRIP_FILTER_TIMEOUT_EN
            tmr_q     <= tmr_d;
            stale_q   <= stale_d;
`endif
        end
    end

    assign ok      = ok_q;
    assign pending = pending_q;
    assign cfg_err = cfg_err_q;
`ifdef TRIP_FILTER_TIMEOUT_EN
    assign stale   = stale_q;
`else
    assign stale   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trip_filter.sv
// ============================================================================
// Module      : tb_trip_filter
// Description : Directed self-checking bench for trip_filter (12/4/8,
//               TIMEOUT=10). Each step pushes the expected {ok, pending,
//               cfg_err, stale} onto a scoreboard queue before the clock
//               edge and pops/compares it one tick after the edge.
//               Watchdog steps are compiled only with TRIP_FILTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trip_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic [11:0] thr_hi;
    logic [11:0] thr_lo;
    logic        ok, pending, cfg_err, stale;

    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   applied = 0;
    int   miss    = 0;
    logic exp_cfg   = 1'b0;
    logic exp_stale = 1'b0;

    trip_filter #(
        .DATA_W    (12),
        .TRIP_CNT  (4),
        .CLEAR_CNT (8),
        .TIMEOUT   (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .ok           (ok),
        .pending      (pending),
        .cfg_err      (cfg_err),
        .stale        (stale)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed=running expected=done");
        $fatal(1, "bench time limit");
    end

    task automatic check_out();
        exp_t       e;
        logic [3:0] obs;
        obs = {ok, pending, cfg_err, stale};
        applied++;
        if (sb.size() == 0) begin
            miss++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                miss++;
                $error("FAIL %s observed={ok,pend,cfg,stale}=%b expected=%b", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step(input logic v, input logic [11:0] s,
                        input logic eok, input logic epend, input string tag);
        exp_t e;
        sample_valid = v;
        sample       = s;
        e.v   = {eok, epend, exp_cfg, exp_stale};
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input logic v, input logic [11:0] s, input string tag);
        exp_t e;
        reset        = 1'b1;
        sample_valid = v;
        sample       = s;
        e.v   = 4'b1000;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
        reset = 1'b0;
    endtask

    // Four out-of-range samples: pending for three, fault after the fourth
    task automatic trip4(input logic [11:0] s, input string tag);
        for (int i = 0; i < 3; i++) step(1'b1, s, 1'b1, 1'b1, {tag, "_pend"});
        step(1'b1, s, 1'b0, 1'b0, {tag, "_trip"});
    endtask

    // Eight in-range samples from TRIPPED: pending for seven, healthy after eight
    task automatic clear8(input logic [11:0] s, input string tag);
        for (int i = 0; i < 7; i++) step(1'b1, s, 1'b0, 1'b1, {tag, "_pend"});
        step(1'b1, s, 1'b1, 1'b0, {tag, "_done"});
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        thr_lo       = 12'd100;
        thr_hi       = 12'd200;

        do_reset(1'b0, 12'd0,   "reset_state");
        do_reset(1'b1, 12'd250, "reset_over_valid");

        // Basic trip with 1-clk latency
        trip4(12'd250, "trip");

        // Clear at the inclusive upper boundary, idle gaps in between
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 12'd200, 1'b0, 1'b1, "clr_gap_pend");
            repeat (5) step(1'b0, 12'd0, 1'b0, 1'b1, "clr_gap_idle");
        end
        step(1'b1, 12'd200, 1'b1, 1'b0, "clr_gap_done");

        // 201 at position 7 aborts the clear
        trip4(12'd250, "trip2");
        for (int i = 0; i < 6; i++) step(1'b1, 12'd200, 1'b0, 1'b1, "clr201_pend");
        step(1'b1, 12'd201, 1'b0, 1'b0, "clr201_abort");
        clear8(12'd200, "clr201_retry");

        // A good sample mid-count restarts the trip count
        for (int i = 0; i < 3; i++) step(1'b1, 12'd250, 1'b1, 1'b1, "gap_pend");
        step(1'b1, 12'd150, 1'b1, 1'b0, "gap_restart");
        for (int i = 0; i < 3; i++) step(1'b1, 12'd250, 1'b1, 1'b1, "gap_notrip");
        step(1'b1, 12'd150, 1'b1, 1'b0, "gap_restart2");

        // Lower boundary and full-scale extremes
        step(1'b1, 12'd99,   1'b1, 1'b1, "lo_99_out");
        step(1'b1, 12'd100,  1'b1, 1'b0, "lo_100_in");
        step(1'b1, 12'd0,    1'b1, 1'b1, "zero_out");
        step(1'b1, 12'd4095, 1'b1, 1'b1, "max_out1");
        step(1'b1, 12'd4095, 1'b1, 1'b1, "max_out2");
        step(1'b1, 12'd4095, 1'b0, 1'b0, "max_trip");
        clear8(12'd150, "clr_mid");

        // Inverted window: cfg_err after 1 clk, every sample out of range
        thr_lo  = 12'd300;
        exp_cfg = 1'b1;
        step(1'b0, 12'd0, 1'b1, 1'b0, "cfg_set");
        trip4(12'd250, "cfg");
        thr_lo  = 12'd100;
        exp_cfg = 1'b0;
        step(1'b0, 12'd0, 1'b0, 1'b0, "cfg_clear");
        clear8(12'd150, "cfg_recover");

        // Reset mid-count discards partial progress
        for (int i = 0; i < 3; i++) step(1'b1, 12'd250, 1'b1, 1'b1, "rst_pend");
        do_reset(1'b1, 12'd250, "rst_midcount");
        for (int i = 0; i < 3; i++) step(1'b1, 12'd250, 1'b1, 1'b1, "rst_notrip");
        step(1'b1, 12'd250, 1'b0, 1'b0, "rst_trip");
        clear8(12'd150, "rst_recover");

`ifdef TRIP_FILTER_TIMEOUT_EN
        // Watchdog: stale and forced trip on the 10th idle cycle
        for (int i = 0; i < 9; i++) step(1'b0, 12'd0, 1'b1, 1'b0, "tmo_idle");
        exp_stale = 1'b1;
        step(1'b0, 12'd0, 1'b0, 1'b0, "tmo_fire");
        step(1'b0, 12'd0, 1'b0, 1'b0, "tmo_hold");
        exp_stale = 1'b0;
        clear8(12'd150, "tmo_recover");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
        $finish;
    end

endmodule

`default_nettype wire
